// File: rtl/bp_assoc_cache.sv
// bp_assoc_cache: set-associative branch-prediction cache for the fetch stage.
// Two combinational lookup ports, one synchronous write port with
// per-set round-robin replacement, and one targeted invalidate port.
// After reset, a sweep clears one set per cycle. This keeps the arrays free
// of a global clear so they can map onto LUTRAM.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ra0/ra1               lookup addresses
//   dout0/dout1           data from the hitting way (0 on miss)
//   hit0/hit1, way0/way1  hit flag and hitting way index (0 on miss)
//   wa, din, we           write address, data, enable
//   ia, inv               invalidate address, enable
//   busy                  reset sweep in progress; lookups forced to miss
//
// Sweep FSM states:
//   state | meaning
//   INIT  | clearing valid bits and rr pointer of set ctr, one set per cycle
//   RUN   | normal operation
module bp_assoc_cache #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  localparam int IW    = $clog2(SETS),
  localparam int TW    = AWIDTH - IW,
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout0,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit0,
  output logic              hit1,
  output logic [WW-1:0]     way0,
  output logic [WW-1:0]     way1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic [AWIDTH-1:0] ia,
  input  logic              inv,
  output logic              busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ctr, ctr_nxt;

  logic [TW-1:0]     tag_mem   [WAYS][SETS];
  logic [DWIDTH-1:0] data_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WW-1:0]     rr_mem    [SETS];

  // Per-way match vector for an address against its indexed set.
  function automatic logic [WAYS-1:0] match_of(input logic [AWIDTH-1:0] a);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    idx = a[IW-1:0];
    tg  = a[AWIDTH-1:IW];
    match_of = '0;
    for (int w = 0; w < WAYS; w++)
      match_of[w] = valid_mem[idx][w] && (tag_mem[w][idx] == tg);
  endfunction

  // Lowest set bit index; 0 when no bit is set.
  function automatic logic [WW-1:0] lowest(input logic [WAYS-1:0] v);
    lowest = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (v[w]) lowest = WW'(w);
  endfunction

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    case (state)
      INIT: begin
        ctr_nxt = ctr + IW'(1);
        if (ctr == IW'(SETS - 1)) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  assign busy = (state == INIT);

  // Lookup ports
  logic [WAYS-1:0] m0, m1;

  always_comb begin
    m0    = match_of(ra0);
    m1    = match_of(ra1);
    hit0  = !busy && (|m0);
    hit1  = !busy && (|m1);
    way0  = hit0 ? lowest(m0) : '0;
    way1  = hit1 ? lowest(m1) : '0;
    dout0 = hit0 ? data_mem[way0][ra0[IW-1:0]] : '0;
    dout1 = hit1 ? data_mem[way1][ra1[IW-1:0]] : '0;
  end

  // Write / invalidate decode
  logic [IW-1:0]   w_idx, i_idx;
  logic [TW-1:0]   w_tag;
  logic [WAYS-1:0] w_match, w_free, i_match;
  logic            w_hit, w_evict, inv_fire;
  logic [WW-1:0]   w_way, rr_next;

  always_comb begin
    w_idx    = wa[IW-1:0];
    w_tag    = wa[AWIDTH-1:IW];
    i_idx    = ia[IW-1:0];
    w_match  = match_of(wa);
    i_match  = match_of(ia);
    w_free   = ~valid_mem[w_idx];
    w_hit    = |w_match;
    w_evict  = !w_hit && !(|w_free);
    w_way    = w_hit ? lowest(w_match) : ((|w_free) ? lowest(w_free) : rr_mem[w_idx]);
    rr_next  = (WAYS == 1) ? '0 : rr_mem[w_idx] + WW'(1);
    // A write to the same set wins; the invalidate is dropped.
    inv_fire = inv && (|i_match) && !(we && (i_idx == w_idx));
  end

  // Arrays carry no reset of their own; the sweep clears valid and rr only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        valid_mem[ctr] <= '0;
        rr_mem[ctr]    <= '0;
      end else begin
        if (we) begin
          tag_mem[w_way][w_idx]    <= w_tag;
          data_mem[w_way][w_idx]   <= din;
          valid_mem[w_idx][w_way]  <= 1'b1;
          if (w_evict) rr_mem[w_idx] <= rr_next;
        end
        if (inv_fire) valid_mem[i_idx] <= valid_mem[i_idx] & ~i_match;
      end
    end
  end

endmodule

// File: tb/tb_bp_assoc_cache.sv
module tb_bp_assoc_cache;
  localparam int AW = 32, DW = 32, SETS = 64, WAYS = 2, IW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra0, ra1, wa, ia;
  logic [DW-1:0] dout0, dout1, din;
  logic          hit0, hit1, we, inv, busy;
  logic [0:0]    way0, way1;

  always #5 clk = ~clk;

  bp_assoc_cache #(.AWIDTH(AW), .DWIDTH(DW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .ra1(ra1), .dout0(dout0), .dout1(dout1),
    .hit0(hit0), .hit1(hit1), .way0(way0), .way1(way1),
    .wa(wa), .din(din), .we(we), .ia(ia), .inv(inv), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain per-set arrays updated by the cache rules.
  bit            mv  [SETS][WAYS];
  logic [25:0]   mt  [SETS][WAYS];
  logic [31:0]   md  [SETS][WAYS];
  int            mrr [SETS];
  bit            m_busy  = 1'b0;
  bit            m_known = 1'b0;
  int            m_cnt   = 0;

  function automatic void m_find(input logic [31:0] a, output bit h, output int w);
    int ix;
    ix = int'(a[IW-1:0]);
    h = 1'b0;
    w = 0;
    for (int k = WAYS - 1; k >= 0; k--)
      if (mv[ix][k] && mt[ix][k] == a[31:IW]) begin h = 1'b1; w = k; end
  endfunction

  function automatic void m_apply();
    bit h;
    int w, wix, iix, fr;
    wix = int'(wa[IW-1:0]);
    iix = int'(ia[IW-1:0]);
    if (we) begin
      m_find(wa, h, w);
      if (!h) begin
        fr = -1;
        for (int k = WAYS - 1; k >= 0; k--) if (!mv[wix][k]) fr = k;
        if (fr >= 0) w = fr;
        else begin
          w = mrr[wix];
          mrr[wix] = (mrr[wix] + 1) % WAYS;
        end
      end
      mv[wix][w] = 1'b1;
      mt[wix][w] = wa[31:IW];
      md[wix][w] = din;
    end
    if (inv && !(we && iix == wix))
      for (int k = 0; k < WAYS; k++)
        if (mv[iix][k] && mt[iix][k] == ia[31:IW]) mv[iix][k] = 1'b0;
  endfunction

  task automatic chk_port(input string p, input logic [31:0] a, input logic h_o,
                          input logic [0:0] w_o, input logic [31:0] d_o);
    bit h;
    int w;
    m_find(a, h, w);
    if (m_busy) h = 1'b0;
    chk({p, "_hit"}, h_o, h);
    chk({p, "_way"}, w_o, h ? w : 0);
    chk({p, "_dout"}, d_o, h ? md[int'(a[IW-1:0])][w] : 32'd0);
  endtask

  // One clock: compare against the model, advance the model, step the DUT.
  task automatic tick();
    #1;
    if (m_known) begin
      chk("busy", busy, m_busy);
      chk_port("p0", ra0, hit0, way0, dout0);
      chk_port("p1", ra1, hit1, way1, dout1);
    end
    if (reset) begin
      m_known = 1'b1;
      m_busy  = 1'b1;
      m_cnt   = 0;
    end else if (m_known && m_busy) begin
      m_cnt++;
      if (m_cnt == SETS) begin
        m_busy = 1'b0;
        foreach (mv[s, k]) mv[s][k] = 1'b0;
        foreach (mrr[s]) mrr[s] = 0;
      end
    end else if (m_known) begin
      m_apply();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pool_addr();
    logic [31:0] t, i;
    t = $urandom_range(0, 4);
    i = $urandom_range(0, 3);
    return (t << IW) | i;
  endfunction

  function automatic logic [31:0] a5(input int t);
    logic [31:0] tt;
    tt = t;
    return (tt << IW) | 32'd5;
  endfunction

  // Run until busy drops (bounded), with random traffic that must be ignored.
  task automatic sweep(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      ra0 = $urandom;
      ra1 = pool_addr();
      wa  = pool_addr();
      din = $urandom;
      we  = $urandom_range(0, 1);
      ia  = pool_addr();
      inv = $urandom_range(0, 1);
      tick();
      n++;
    end
    we = 1'b0;
    inv = 1'b0;
    chk(tag, n, SETS);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ra0 = '0; ra1 = '0; wa = '0; ia = '0; din = '0; we = 1'b0; inv = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    sweep("sweep_len_first");

    // Written entry must not survive a second sweep.
    we = 1'b1; wa = 32'h100; din = 32'h1234; tick(); we = 1'b0;
    ra0 = 32'h100; #1; chk("pre_reset_0x100_hit", hit0, 1'b1);
    do_reset(2);
    sweep("sweep_len");
    ra0 = 32'h100; #1; chk("post_sweep_0x100_hit", hit0, 1'b0);
    tick();

    // Allocate then update in place.
    we = 1'b1; wa = 32'h104; din = 32'hAAAA; tick();
    din = 32'hBBBB; tick(); we = 1'b0;
    ra0 = 32'h104; ra1 = 32'h204; #1;
    chk("upd_hit", hit0, 1'b1);
    chk("upd_dout", dout0, 32'hBBBB);
    chk("upd_way", way0, 1'b0);
    chk("other_tag_miss", hit1, 1'b0);
    we = 1'b1; wa = 32'h204; din = 32'hCCCC; tick(); we = 1'b0;
    #1; chk("second_tag_way1", way1, 1'b1);
    tick();

    // Conflicts and round-robin in set 5.
    we = 1'b1;
    for (int t = 1; t <= 2; t++) begin wa = a5(t); din = 32'h50 + t; tick(); end
    we = 1'b0; ra0 = a5(1); ra1 = a5(2); #1;
    chk("t0_way", way0, 1'b0);
    chk("t1_way", way1, 1'b1);
    we = 1'b1; wa = a5(3); din = 32'h53; tick(); we = 1'b0;
    ra0 = a5(1); ra1 = a5(3); #1;
    chk("t0_evicted", hit0, 1'b0);
    chk("t2_way0", {hit1, way1}, 2'b10);
    we = 1'b1; wa = a5(4); din = 32'h54; tick(); we = 1'b0;
    ra0 = a5(2); ra1 = a5(4); #1;
    chk("t1_evicted", hit0, 1'b0);
    chk("t3_way1", {hit1, way1}, 2'b11);
    tick();

    // Dual read with same-cycle write to the resident address.
    ra0 = a5(3); ra1 = 32'h0000_0EEE; we = 1'b1; wa = a5(3); din = 32'h99; #1;
    chk("dual_hit0", hit0, 1'b1);
    chk("dual_old_dout0", dout0, 32'h53);
    chk("dual_hit1", hit1, 1'b0);
    chk("dual_dout1", dout1, 32'h0);
    tick(); we = 1'b0; #1;
    chk("dual_new_dout0", dout0, 32'h99);
    tick();

    // Invalidate one way, neighbour untouched.
    inv = 1'b1; ia = a5(3); tick(); inv = 1'b0;
    ra0 = a5(3); ra1 = a5(4); #1;
    chk("inv_miss", hit0, 1'b0);
    chk("inv_neighbour", {hit1, way1}, 2'b11);
    tick();
    // Same-index write and invalidate: write lands, invalidate dropped.
    inv = 1'b1; ia = a5(4); we = 1'b1; wa = a5(6); din = 32'h77; tick();
    inv = 1'b0; we = 1'b0; ra0 = a5(6); ra1 = a5(4); #1;
    chk("same_idx_write", {hit0, way0}, 2'b10);
    chk("same_idx_inv_dropped", hit1, 1'b1);
    tick();
    // Different index: both apply.
    inv = 1'b1; ia = a5(6); we = 1'b1; wa = 32'h0000_01C7; din = 32'h66; tick();
    inv = 1'b0; we = 1'b0; ra0 = a5(6); ra1 = 32'h0000_01C7; #1;
    chk("diff_idx_inv", hit0, 1'b0);
    chk("diff_idx_write", dout1, 32'h66);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ra0 = pool_addr(); ra1 = pool_addr(); wa = pool_addr(); ia = pool_addr();
      din = $urandom; we = ($urandom_range(0, 1) == 1); inv = ($urandom_range(0, 2) == 0);
      tick();
    end
    we = 1'b0; inv = 1'b0;

    // Reset mid-sweep at ctr=30 with write pulses during busy.
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      wa = pool_addr(); din = $urandom; we = $urandom_range(0, 1); ra0 = pool_addr(); tick();
    end
    we = 1'b0;
    do_reset(1);
    sweep("restart_sweep_len");
    for (int t = 0; t <= 4; t++)
      for (int i = 0; i <= 3; i++) begin
        logic [31:0] tt, ii;
        tt = t; ii = i;
        ra0 = (tt << IW) | ii; #1;
        chk("no_valid_after_sweep", hit0, 1'b0);
        tick();
      end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
